// File: rtl/ej32_pkg.sv
// Shared eJ32 opcode encoding, sequencer state type and branch-unit opcode helpers.
package ej32_pkg;

  localparam int ASZ_DEF = 17;
  localparam int SSZ_DEF = 6;

  typedef enum logic [7:0] {
    OP_ILOAD         = 8'h15,
    OP_ILOAD_0       = 8'h1A,
    OP_ILOAD_1       = 8'h1B,
    OP_ILOAD_2       = 8'h1C,
    OP_ILOAD_3       = 8'h1D,
    OP_ISTORE_0      = 8'h3B,
    OP_IFEQ          = 8'h99,
    OP_IFNE          = 8'h9A,
    OP_IFLT          = 8'h9B,
    OP_IFGE          = 8'h9C,
    OP_IFGT          = 8'h9D,
    OP_IFLE          = 8'h9E,
    OP_IF_ICMPEQ     = 8'h9F,
    OP_IF_ICMPNE     = 8'hA0,
    OP_IF_ICMPLT     = 8'hA1,
    OP_IF_ICMPGT     = 8'hA3,
    OP_GOTO          = 8'hA7,
    OP_JSR           = 8'hA8,
    OP_RET           = 8'hA9,
    OP_JRETURN       = 8'hB1,
    OP_INVOKEVIRTUAL = 8'hB6,
    OP_DONEXT        = 8'hCA,
    OP_DUPR          = 8'hCB,
    OP_POPR          = 8'hCC,
    OP_PUSHR         = 8'hCD
  } opcode_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_FLUSH = 2'd2,
    S_ERR   = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic       vld;
    logic [2:0] last;
  } br_class_t;

  // vld=0 marks opcodes the branching unit does not handle.
  function automatic br_class_t br_last_phase(input opcode_t op);
    br_class_t c;
    c.vld  = 1'b1;
    c.last = 3'd0;
    case (op)
      OP_ILOAD, OP_ILOAD_0, OP_ILOAD_1, OP_ILOAD_2, OP_ILOAD_3, OP_ISTORE_0,
      OP_RET, OP_JRETURN, OP_DUPR, OP_POPR, OP_PUSHR:
        c.last = 3'd0;
      OP_IFEQ, OP_IFNE, OP_IFLT, OP_IFGE, OP_IFGT, OP_IFLE,
      OP_IF_ICMPEQ, OP_IF_ICMPNE, OP_IF_ICMPLT, OP_IF_ICMPGT,
      OP_GOTO, OP_INVOKEVIRTUAL, OP_DONEXT:
        c.last = 3'd1;
      OP_JSR:
        c.last = 3'd2;
      default:
        c.vld = 1'b0;
    endcase
    return c;
  endfunction

  function automatic logic signed [1:0] rs_delta(input opcode_t op, input logic [2:0] phase,
                                                 input logic r_zero);
    logic signed [1:0] d;
    d = 2'sb00;
    case (op)
      OP_PUSHR:         d = 2'sb01;
      OP_INVOKEVIRTUAL: d = (phase == 3'd0) ? 2'sb01 : 2'sb00;
      OP_POPR,
      OP_JRETURN:       d = 2'sb11;
      OP_DONEXT:        d = (phase == 3'd1 && r_zero) ? 2'sb11 : 2'sb00;
      default:          d = 2'sb00;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ej32_rs_depth.sv
// Mirror of the return-stack pointer: bounded up/down counter that refuses
// to wrap and latches a sticky error instead.
module ej32_rs_depth
  #(parameter int SSZ = 6)
  (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic signed [1:0] i_delta,
    output logic [SSZ:0]      o_depth,
    output logic              o_viol,
    output logic              o_err
  );

  localparam logic [SSZ:0] DEPTH_MAX = {1'b1, {SSZ{1'b0}}};

  logic [SSZ:0] r_depth;
  logic         r_err;
  logic         w_push;
  logic         w_pop;

  assign w_push  = i_en && (i_delta == 2'sb01);
  assign w_pop   = i_en && (i_delta == 2'sb11);
  assign o_viol  = (w_push && r_depth == DEPTH_MAX) || (w_pop && r_depth == '0);
  assign o_depth = r_depth;
  assign o_err   = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_depth <= '0;
      r_err   <= 1'b0;
    end else if (o_viol) begin
      r_err   <= 1'b1;
    end else if (w_push) begin
      r_depth <= r_depth + 1'b1;
    end else if (w_pop) begin
      r_depth <= r_depth - 1'b1;
    end
  end

endmodule

// File: rtl/ej32_br_seq.sv
// Phase sequencer for the eJ32 branching unit: steps each BR opcode through its
// operand phases, stalls on memory waits, flushes after taken jumps, guards the return stack.
module ej32_br_seq
  import ej32_pkg::*;
  #(
    parameter int ASZ = ASZ_DEF,
    parameter int SSZ = SSZ_DEF
  )
  (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   code,
    input  logic         code_vld,
    input  logic         mem_rdy,
    input  logic         br_psel,
    input  logic         r_zero,
    output logic [2:0]   phase,
    output logic         br_en,
    output logic         busy,
    output logic         flush,
    output logic         done,
    output logic [SSZ:0] depth,
    output logic         rs_err,
    output logic [1:0]   dbg_state
  );

  // Handshake: code_vld is a one-cycle strobe honoured only while busy=0;
  // br_en is the commit qualifier and a phase advances on each br_en cycle.
  seq_state_t        r_state;
  seq_state_t        w_next;
  opcode_t           r_op;
  logic [2:0]        r_last;
  logic [2:0]        r_phase;
  logic              r_done;
  logic              r_flush;
  br_class_t         w_cls;
  logic              w_accept;
  logic              w_br_en;
  logic              w_final;
  logic signed [1:0] w_delta;
  logic              w_viol;

  assign w_cls    = br_last_phase(opcode_t'(code));
  assign w_accept = (r_state == S_IDLE) && code_vld && w_cls.vld;
  assign w_br_en  = (r_state == S_EXEC) && mem_rdy;
  assign w_final  = w_br_en && (r_phase == r_last);
  assign w_delta  = rs_delta(r_op, r_phase, r_zero);

  ej32_rs_depth #(.SSZ(SSZ)) u_rs_depth (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_br_en),
    .i_delta (w_delta),
    .o_depth (depth),
    .o_viol  (w_viol),
    .o_err   (rs_err)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_EXEC;
      S_EXEC:  if (w_final) w_next = br_psel ? S_FLUSH : S_IDLE;
      S_FLUSH: w_next = S_IDLE;
      S_ERR:   w_next = S_ERR;
      default: w_next = S_ERR;
    endcase
    // A stack violation overrides any retire decision made in the same cycle.
    if (w_viol) w_next = S_ERR;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= opcode_t'(8'h00);
      r_last  <= 3'd0;
      r_phase <= 3'd0;
      r_done  <= 1'b0;
      r_flush <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_final && !w_viol;
      r_flush <= w_final && !w_viol && br_psel;
      if (w_accept) begin
        r_op    <= opcode_t'(code);
        r_last  <= w_cls.last;
        r_phase <= 3'd0;
      end else if (w_final && !w_viol) begin
        r_phase <= 3'd0;
      end else if (w_br_en && !w_viol) begin
        r_phase <= r_phase + 3'd1;
      end
    end
  end

  assign phase     = r_phase;
  assign br_en     = w_br_en;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign flush     = r_flush;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_ej32_br_seq.sv
// Directed and randomized bench for ej32_br_seq, checked against an opcode-table
// model of phase count, retire timing and return-stack depth.
module tb_ej32_br_seq;

  localparam int SSZ   = 6;
  localparam int D_MAX = 2 ** SSZ;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]   code     = 8'h00;
  logic         code_vld = 1'b0;
  logic         mem_rdy  = 1'b0;
  logic         br_psel  = 1'b0;
  logic         r_zero   = 1'b0;
  logic [2:0]   phase;
  logic         br_en;
  logic         busy;
  logic         flush;
  logic         done;
  logic [SSZ:0] depth;
  logic         rs_err;
  logic [1:0]   dbg_state;

  ej32_br_seq #(.ASZ(17), .SSZ(SSZ)) dut (
    .clk       (clk),
    .rst       (rst),
    .code      (code),
    .code_vld  (code_vld),
    .mem_rdy   (mem_rdy),
    .br_psel   (br_psel),
    .r_zero    (r_zero),
    .phase     (phase),
    .br_en     (br_en),
    .busy      (busy),
    .flush     (flush),
    .done      (done),
    .depth     (depth),
    .rs_err    (rs_err),
    .dbg_state (dbg_state)
  );

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;
  int m_depth = 0;

  logic [7:0] op_tab [0:27] = '{
    8'h15, 8'h1A, 8'h1B, 8'h1C, 8'h1D, 8'h3B, 8'hA9, 8'hB1, 8'hCB, 8'hCC,
    8'hCD, 8'h99, 8'h9A, 8'h9B, 8'h9C, 8'h9D, 8'h9E, 8'h9F, 8'hA0, 8'hA1,
    8'hA3, 8'hA7, 8'hB6, 8'hCA, 8'hA8, 8'h60, 8'h00, 8'hCD
  };

  // reference model: last phase of an opcode (-1 = not a branch-unit op)
  function automatic int model_last(input logic [7:0] op);
    case (op)
      8'h15, 8'h1A, 8'h1B, 8'h1C, 8'h1D, 8'h3B, 8'hA9, 8'hB1, 8'hCB, 8'hCC, 8'hCD: return 0;
      8'h99, 8'h9A, 8'h9B, 8'h9C, 8'h9D, 8'h9E, 8'h9F, 8'hA0, 8'hA1, 8'hA3,
      8'hA7, 8'hB6, 8'hCA: return 1;
      8'hA8: return 2;
      default: return -1;
    endcase
  endfunction

  // reference model: stack effect of the operand byte consumed at step k
  function automatic int model_delta(input logic [7:0] op, input int k, input bit rz);
    if (op == 8'hCD) return 1;
    if (op == 8'hB6 && k == 0) return 1;
    if (op == 8'hCC || op == 8'hB1) return -1;
    if (op == 8'hCA && k == 1 && rz) return -1;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; code_vld = 1'b0; mem_rdy = 1'b0;
    #1;
    chk("rst_rs_err", rs_err, 0);
    chk("rst_depth", depth, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    m_depth = 0;
  endtask

  // driver: issue one opcode and follow it to retire (or to the stack error)
  task automatic run_op(input logic [7:0] op, input bit psel, input bit rz,
                        input int stall_first, input int stall_pct, output bit err);
    int L;
    int k;
    int d;
    int stalls;
    err = 1'b0;
    L = model_last(op);
    @(negedge clk);
    code = op; code_vld = 1'b1;
    mem_rdy = 1'($urandom_range(0, 1)); br_psel = 1'($urandom_range(0, 1));
    #1;
    chk("issue_busy", busy, 0);
    chk("issue_br_en", br_en, 0);
    if (L < 0) begin
      @(negedge clk);
      code_vld = 1'b0;
      #1;
      chk("nonbr_busy", busy, 0);
      chk("nonbr_done", done, 0);
      return;
    end
    k = 0;
    stalls = 0;
    for (int cyc = 0; cyc < 300 && k <= L; cyc++) begin
      @(negedge clk);
      // decoder strobes while busy must be ignored
      code_vld = ($urandom_range(0, 3) == 0);
      code     = 8'hA7;
      mem_rdy  = (stalls < stall_first) ? 1'b0 : ($urandom_range(0, 99) >= stall_pct);
      br_psel  = (k == L) ? psel : 1'($urandom_range(0, 1));
      r_zero   = (k == 1) ? rz : 1'($urandom_range(0, 1));
      #1;
      chk("exec_busy", busy, 1);
      chk("exec_br_en", br_en, mem_rdy);
      chk("exec_phase", phase, k);
      chk("exec_depth", depth, m_depth);
      chk("exec_done", done, 0);
      chk("exec_flush", flush, 0);
      if (!mem_rdy) begin
        stalls++;
      end else begin
        d = model_delta(op, k, rz);
        if (m_depth + d < 0 || m_depth + d > D_MAX) begin
          err = 1'b1;
          break;
        end
        m_depth += d;
        k++;
      end
    end
    if (!err && k <= L) begin
      n_total++;
      n_fail++;
      $error("FAIL exec_timeout: observed phase %0d expected retire", k);
      return;
    end
    @(negedge clk);
    code_vld = 1'b0;
    mem_rdy  = 1'($urandom_range(0, 1));
    #1;
    if (err) begin
      chk("err_rs_err", rs_err, 1);
      chk("err_depth", depth, m_depth);
      chk("err_busy", busy, 1);
      chk("err_done", done, 0);
      chk("err_br_en", br_en, 0);
      @(negedge clk);
      code = 8'hA7; code_vld = 1'b1; mem_rdy = 1'b1;
      #1;
      chk("err_absorb_busy", busy, 1);
      chk("err_absorb_br_en", br_en, 0);
      @(negedge clk);
      code_vld = 1'b0;
      #1;
      chk("err_absorb_rs_err", rs_err, 1);
      return;
    end
    chk("retire_done", done, 1);
    chk("retire_flush", flush, psel);
    chk("retire_busy", busy, psel);
    chk("retire_br_en", br_en, 0);
    chk("retire_depth", depth, m_depth);
    if (psel) begin
      @(negedge clk);
      #1;
      chk("post_flush_done", done, 0);
      chk("post_flush_flush", flush, 0);
      chk("post_flush_busy", busy, 0);
    end
  endtask

  initial begin
    bit err;
    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("reset_phase", phase, 0);
    chk("reset_depth", depth, 0);
    chk("reset_done", done, 0);
    chk("reset_flush", flush, 0);
    chk("reset_rs_err", rs_err, 0);
    chk("reset_busy", busy, 0);
    chk("reset_br_en", br_en, 0);
    @(negedge clk);
    rst = 1'b0;

    // goto taken, no stalls
    run_op(8'hA7, 1'b1, 1'b0, 0, 0, err);
    // ifeq not taken, two stall cycles in phase 0
    run_op(8'h99, 1'b0, 1'b0, 2, 0, err);
    // jsr taken: three phases then flush
    run_op(8'hA8, 1'b1, 1'b0, 0, 0, err);
    // L=0 ops
    run_op(8'h15, 1'b0, 1'b0, 0, 20, err);
    run_op(8'hA9, 1'b1, 1'b0, 0, 20, err);

    // overflow: fill the stack, then one push too many
    do_reset();
    for (int i = 0; i < D_MAX; i++) run_op(8'hCD, 1'b0, 1'b0, 0, 0, err);
    chk("full_depth", depth, D_MAX);
    run_op(8'hCD, 1'b0, 1'b0, 0, 0, err);
    do_reset();

    // underflow at depth 0
    run_op(8'hCC, 1'b0, 1'b0, 0, 0, err);
    do_reset();

    // donext with and without r_zero at depth 3
    for (int i = 0; i < 3; i++) run_op(8'hCD, 1'b0, 1'b0, 0, 0, err);
    run_op(8'hCA, 1'b0, 1'b1, 0, 0, err);
    chk("donext_rz1_depth", depth, 2);
    run_op(8'hCD, 1'b0, 1'b0, 0, 0, err);
    run_op(8'hCA, 1'b0, 1'b0, 0, 0, err);
    chk("donext_rz0_depth", depth, 3);

    // reset in phase 1 of invokevirtual
    do_reset();
    @(negedge clk);
    code = 8'hB6; code_vld = 1'b1; mem_rdy = 1'b1; br_psel = 1'b0;
    @(negedge clk);
    code_vld = 1'b0;
    #1;
    chk("inv_p0_br_en", br_en, 1);
    @(negedge clk);
    #1;
    chk("inv_p1_phase", phase, 1);
    chk("inv_p1_depth", depth, 1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_phase", phase, 0);
    chk("midrst_depth", depth, 0);
    chk("midrst_done", done, 0);
    chk("midrst_flush", flush, 0);
    chk("midrst_rs_err", rs_err, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_br_en", br_en, 0);
    @(negedge clk);
    rst = 1'b0;
    m_depth = 0;
    run_op(8'hA7, 1'b1, 1'b0, 0, 0, err);

    // randomized opcode mix
    for (int i = 0; i < 80; i++) begin
      run_op(op_tab[$urandom_range(0, 27)], 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 0, 30, err);
      if (err) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ej32_br_seq.md
# ej32_br_seq

Phase sequencer and return-stack depth guard for the eJ32 branching unit. It classifies each decoded opcode and generates the multi-cycle `phase` count and the `br_en` qualifier that the branching unit consumes. It stalls on memory wait states and issues a one-cycle pipeline flush after a taken jump. It mirrors the return-stack pointer so overflow and underflow are caught before the block RAM wraps. It sits between the decoder/fetch logic and the branching unit on the shared control bus.

## Interface
Parameters:
- `ASZ`, 17, address width (passed through for package consistency).
- `SSZ`, 6, return-stack pointer width; the stack holds `2**SSZ` entries.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `code`  in  8  current opcode (`opcode_t` from `ej32_pkg`).
- `code_vld`  in  1  `code` is valid and newly fetched (single-cycle strobe).
- `mem_rdy`  in  1  operand byte on the memory bus is valid this cycle.
- `br_psel`  in  1  jump-taken indication from the branching unit.
- `r_zero`  in  1  top of return stack equals 0 (used by `donext`).
- `phase`  out  3  current phase to the branching unit.
- `br_en`  out  1  branching unit may commit this cycle.
- `busy`  out  1  sequencer owns the pipeline; the decoder must not issue.
- `flush`  out  1  fetch unit discards its prefetched byte.
- `done`  out  1  one-cycle pulse at instruction retire.
- `depth`  out  SSZ+1  mirrored return-stack depth.
- `rs_err`  out  1  sticky overflow/underflow flag.

## Operation
- Opcode class, which gives the last phase `L`:
  - `L=0`: `iload`, `iload_0..3`, `istore_0`, `ret`, `jreturn`, `dupr`, `popr`, `pushr`.
  - `L=1`: `ifeq..ifle`, `if_icmpeq/ne/lt/gt`, `goto`, `invokevirtual`, `donext`.
  - `L=2`: `jsr`.
  - Any other opcode is not a BR op and is ignored.
- States:
  - IDLE: on `code_vld` with a BR opcode, latch the opcode and `L`, set `phase=0`, and go to EXEC.
  - EXEC: on a cycle where `mem_rdy=1`:
    - if `phase<L`, increment `phase`;
    - if `phase==L`, go to FLUSH when `br_psel=1`, otherwise go to IDLE and pulse `done`.
    - With `mem_rdy=0`, everything holds.
  - FLUSH: assert `flush` for one cycle, pulse `done`, then go to IDLE.
  - ERR: entered from any state when a depth violation occurs; absorbing until `rst`.
- `br_en = (state==EXEC) & mem_rdy`.
- `busy` is high in EXEC, FLUSH and ERR.
- Depth tracking is applied only on cycles where `br_en=1`:
  - `depth+1` for `pushr`, and for `invokevirtual` at phase 0.
  - `depth-1` for `popr`, for `jreturn`, and for `donext` at phase 1 with `r_zero=1`.
  - A push at `depth==2**SSZ`, or a pop at `depth==0`, sets `rs_err`, leaves `depth` unchanged and enters ERR.
- A `code_vld` that arrives while `busy=1` is a decoder protocol error. It is ignored, and the state does not change.

## Timing
- Reset values (asynchronous):
  - state IDLE;
  - `phase`, `depth`, `done`, `flush` and `rs_err` all 0;
  - `busy` 0;
  - `br_en` 0.
- Latency:
  - an `L=0` op retires with `done` one cycle after its `br_en` cycle;
  - an `L`-phase op takes at least `L+1` EXEC cycles, plus one cycle per `mem_rdy=0` cycle;
  - a taken jump adds exactly one FLUSH cycle.
- `phase` is registered and changes only on the clock edge that follows a `br_en` cycle.
- `br_en` is combinational from state and `mem_rdy`, with no added latency.
- `br_psel` is sampled only on the final `br_en` cycle (`phase==L`). Its value at earlier phases does not matter.
- Reset asserted mid-instruction clears everything asynchronously; no `done` pulse is produced for the aborted op.

## Structure
- `ej32_pkg` holds:
  - the `seq_state_t` enum (IDLE, EXEC, FLUSH, ERR);
  - the function `br_last_phase(opcode_t)`, which returns `L` and a valid bit;
  - the function `rs_delta(opcode_t, phase, r_zero)`, which returns -1, 0 or +1.
- The top level is a single module `ej32_br_seq`.
- One natural sub-module is `ej32_rs_depth`: the saturating up/down counter with its error detect.

## Test plan
- `goto` (0xA7) with `mem_rdy=1` and `br_psel=1` at phase 1 -> `phase` goes 0,1; `br_en` is high for 2 cycles; `flush` for 1 cycle; `done` on cycle 4.
- `ifeq` (0x99) with `br_psel=0`, and `mem_rdy` low for 2 cycles during phase 0 -> `phase` holds at 0 for 2 cycles; `br_en` is low for those 2 cycles; `done` comes without `flush`, 5 cycles after `code_vld`.
- `jsr` (0xA8) -> phases 0,1,2, then FLUSH; `busy` is high for 4 cycles.
- `2**SSZ` `pushr` ops, then one more `pushr` -> `depth` reaches 64 (with `SSZ=6`); the 65th sets `rs_err`, `depth` stays 64, and `busy` stays high.
- `popr` at reset depth 0 -> `rs_err=1`, `depth` stays 0. Separately, `donext` with `r_zero=1` at depth 3 -> `depth=2`; with `r_zero=0` -> `depth` stays 3.
- Assert `rst` in phase 1 of `invokevirtual` -> all outputs are 0 immediately; a new `goto` is accepted on the next `code_vld`.
